// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ready pipeline stages: default widths and
// the skid buffer occupancy states.
package handshake_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 16;

    // Encoding equals occupancy, so the state register doubles as the level output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_stage_if.sv
// Valid/ready handshake bundle around the skid stage: upstream producer side
// and downstream destination side.
interface skid_stage_if
    import handshake_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [DW-1:0] dn_data;

    // slave: the stage itself; master: the surrounding producer/consumer.
    modport slave (
        input  up_valid, up_data, dn_ready,
        output up_ready, dn_valid, dn_data
    );

    modport master (
        output up_valid, up_data, dn_ready,
        input  up_ready, dn_valid, dn_data
    );
endinterface

// File: rtl/beat_counter.sv
// Wrapping beat counter with synchronous reset and count enable.
module beat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/skid_stage.sv
// Fully registered valid/ready stage with a two-entry skid buffer; every
// output toward either neighbour comes straight from a flop.
module skid_stage
    import handshake_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    skid_stage_if.slave   hs,
    output logic [1:0]    level,
    output logic [CW-1:0] in_cnt,
    output logic [CW-1:0] out_cnt
);

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          up_ready_q;
    logic          dn_valid_q;
    logic          accept;
    logic          take;

    assign accept = hs.up_valid && up_ready_q;
    assign take   = dn_valid_q && hs.dn_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = hs.up_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && take) begin
                    main_d = hs.up_data;
                end else if (accept) begin
                    skid_d  = hs.up_data;
                    state_d = FULL;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are flopped from the next state, so dn_ready never
    // reaches up_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            up_ready_q <= 1'b0;
            dn_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            up_ready_q <= (state_d != FULL);
            dn_valid_q <= (state_d != EMPTY);
        end
    end

    assign hs.up_ready = up_ready_q;
    assign hs.dn_valid = dn_valid_q;
    assign hs.dn_data  = main_q;
    assign level       = state_q;

    beat_counter #(.CW(CW)) u_in_cnt (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .cnt (in_cnt)
    );

    beat_counter #(.CW(CW)) u_out_cnt (
        .clk (clk),
        .rst (rst),
        .en  (take),
        .cnt (out_cnt)
    );

endmodule

// File: tb/tb_skid_stage.sv
// Scoreboard bench for skid_stage: a 16-bit-counter instance and a 4-bit-counter
// instance share the same stimulus and are both checked against one queue model.
module tb_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  level, level4;
    logic [15:0] in_cnt, out_cnt;
    logic [3:0]  in_cnt4, out_cnt4;

    skid_stage_if #(.DW(8)) hs ();
    skid_stage_if #(.DW(8)) hs4 ();

    skid_stage #(.DW(8), .CW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
        .level   (level),
        .in_cnt  (in_cnt),
        .out_cnt (out_cnt)
    );

    skid_stage #(.DW(8), .CW(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs4),
        .level   (level4),
        .in_cnt  (in_cnt4),
        .out_cnt (out_cnt4)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] q[$];
    int         ic     = 0;
    int         oc     = 0;
    logic       blk    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expectations reflect the state after the last edge; the model then
    // applies whatever handshake the coming edge will perform.
    always @(negedge clk) begin
        chk("dn_valid", 32'(hs.dn_valid), 32'(q.size() != 0));
        chk("up_ready", 32'(hs.up_ready), 32'(!blk && q.size() < 2));
        chk("level", 32'(level), 32'(q.size()));
        chk("in_cnt", 32'(in_cnt), ic & 32'hFFFF);
        chk("out_cnt", 32'(out_cnt), oc & 32'hFFFF);
        chk("level4", 32'(level4), 32'(q.size()));
        chk("in_cnt4", 32'(in_cnt4), ic & 32'hF);
        chk("out_cnt4", 32'(out_cnt4), oc & 32'hF);
        if (q.size() != 0) begin
            chk("dn_data", 32'(hs.dn_data), 32'(q[0]));
            chk("dn_data4", 32'(hs4.dn_data), 32'(q[0]));
        end
        if (rst) begin
            q.delete();
            ic  = 0;
            oc  = 0;
            blk = 1'b1;
        end else begin
            blk = 1'b0;
            if (hs.dn_valid && hs.dn_ready && q.size() != 0) begin
                void'(q.pop_front());
                oc++;
            end
            if (hs.up_valid && hs.up_ready) begin
                q.push_back(hs.up_data);
                ic++;
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, output logic acc);
        hs.up_valid  = v;
        hs.up_data   = d;
        hs.dn_ready  = r;
        hs4.up_valid = v;
        hs4.up_data  = d;
        hs4.dn_ready = r;
        acc = v && hs.up_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic acc;
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, acc);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic send(input logic [7:0] d, input logic r);
        logic acc;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, d, r, acc);
            if (acc) return;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 64; i++) begin
            if (q.size() == 0 && !hs.dn_valid) return;
            cyc(1'b0, 8'h00, 1'b1, acc);
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic acc;
        int   idx;
        hs.up_valid  = 1'b0;
        hs.up_data   = 8'h00;
        hs.dn_ready  = 1'b0;
        hs4.up_valid = 1'b0;
        hs4.up_data  = 8'h00;
        hs4.dn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, acc);

        // streaming at full rate
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(i), 1'b1, acc);
            chk("stream_acc", 32'(acc), 32'd1);
            chk("stream_level", 32'(level), 32'd1);
        end
        drain();
        chk("stream_in_cnt", 32'(in_cnt), 32'd10);
        chk("stream_out_cnt", 32'(out_cnt), 32'd10);

        // stall: second beat lands in the skid register
        do_reset();
        cyc(1'b1, 8'h10, 1'b1, acc);
        chk("stall_acc10", 32'(acc), 32'd1);
        cyc(1'b1, 8'h11, 1'b0, acc);
        chk("stall_acc11", 32'(acc), 32'd1);
        chk("stall_level", 32'(level), 32'd2);
        chk("stall_up_ready", 32'(hs.up_ready), 32'd0);
        chk("stall_dn_data", 32'(hs.dn_data), 32'h10);
        cyc(1'b1, 8'h12, 1'b0, acc);
        chk("stall_blocked", 32'(acc), 32'd0);
        chk("stall_hold", 32'(hs.dn_data), 32'h10);
        send(8'h12, 1'b1);
        drain();
        chk("stall_in_cnt", 32'(in_cnt), 32'd3);
        chk("stall_out_cnt", 32'(out_cnt), 32'd3);

        // bubbles
        do_reset();
        cyc(1'b1, 8'hA0, 1'b1, acc);
        cyc(1'b0, 8'h00, 1'b1, acc);
        chk("bubble_gap", 32'(hs.dn_valid), 32'd0);
        cyc(1'b1, 8'hA1, 1'b1, acc);
        cyc(1'b0, 8'h00, 1'b1, acc);
        drain();
        chk("bubble_count", 32'(out_cnt), 32'd2);

        // random traffic with random backpressure
        do_reset();
        idx = 0;
        for (int c = 0; c < 20000 && idx < 1000; c++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'(idx * 37 + 5), 1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
        end
        chk("random_done", 32'(idx), 32'd1000);
        drain();
        chk("random_out_cnt", 32'(out_cnt), 32'd1000);

        // reset while FULL discards both buffered beats
        do_reset();
        cyc(1'b1, 8'h55, 1'b0, acc);
        cyc(1'b1, 8'h66, 1'b0, acc);
        chk("rst_full", 32'(level), 32'd2);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, acc);
        rst = 1'b0;
        chk("rst_dn_valid", 32'(hs.dn_valid), 32'd0);
        chk("rst_up_ready", 32'(hs.up_ready), 32'd0);
        chk("rst_in_cnt", 32'(in_cnt), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, acc);
        chk("rst_up_ready1", 32'(hs.up_ready), 32'd1);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, acc);

        // counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) send(8'(8'hC0 + i), 1'b1);
        drain();
        chk("wrap_in_cnt4", 32'(in_cnt4), 32'd4);
        chk("wrap_out_cnt4", 32'(out_cnt4), 32'd4);
        chk("wrap_in_cnt16", 32'(in_cnt), 32'd20);

        repeat (2) cyc(1'b0, 8'h00, 1'b0, acc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/skid_stage.md
# skid_stage

Fully registered valid/ready pipeline stage with a two-entry skid buffer, placed directly upstream of the destination sink in the handshake pipeline. Every output toward both neighbours (`up_ready`, `dn_valid`, `dn_data`) comes from a flop, breaking the ready and data timing paths. The stage sustains one beat per cycle and never drops or duplicates a beat. Beat counters are exported for bench scoreboarding.

## Interface
Parameters:
- `DW`, default 8: data width, bits.
- `CW`, default 16: width of the beat counters.

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `up_valid`, in, 1: upstream beat valid.
- `up_ready`, out, 1: stage can accept; registered.
- `up_data`, in, `DW`: upstream beat payload.
- `dn_valid`, out, 1: beat presented to the destination; registered.
- `dn_ready`, in, 1: destination accepts.
- `dn_data`, out, `DW`: payload presented downstream; registered.
- `level`, out, 2: occupancy, 0 to 2.
- `in_cnt`, out, `CW`: count of accepted upstream beats; wraps.
- `out_cnt`, out, `CW`: count of delivered downstream beats; wraps.

## Operation
- Accept is `up_valid && up_ready`. Take is `dn_valid && dn_ready`.
- Storage: main register `main_q` drives `dn_data`; skid register `skid_q` holds overflow.
- States and transitions:
  - EMPTY (level 0): on accept, load `main_q <= up_data` and go to BUSY.
  - BUSY (level 1):
    - accept with take: `main_q <= up_data`, stay in BUSY.
    - accept without take: `skid_q <= up_data`, go to FULL.
    - take without accept: go to EMPTY.
    - neither: hold.
  - FULL (level 2): `up_ready` is 0, so no accept is possible. On take, `main_q <= skid_q` and go to BUSY; otherwise hold.
- `dn_valid` = (state != EMPTY). `up_ready` = (state != FULL). Both are registered from next-state, not decoded combinationally from inputs.
- While `dn_valid && !dn_ready`, `dn_data` must not change.
- `up_data` is sampled only on an accept cycle; its value on other cycles is don't-care.
- Ordering is strict FIFO. The skid beat is always delivered after the main beat.
- Counters: `in_cnt` increments on each accept and `out_cnt` on each take, wrapping modulo 2^`CW` with no saturation. The invariant `in_cnt - out_cnt` (mod 2^`CW`) == `level` always holds.

## Timing
- Reset values: state EMPTY, `up_ready` 0, `dn_valid` 0, `dn_data` 0, `skid_q` 0, `level` 0, `in_cnt` 0, `out_cnt` 0.
- First rising edge with `rst` low sets `up_ready` to 1. No beat can be accepted during reset or in that first cycle.
- Latency: a beat accepted at edge N appears with `dn_valid` = 1 after edge N, so it is takeable at edge N+1. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle while `dn_ready` is held high. In that case `level` stays at 1 and the skid register is unused.
- Backpressure: when `dn_ready` drops, one more beat is absorbed into `skid_q` and `up_ready` falls at the same edge. No combinational path from `dn_ready` to `up_ready`.
- Simultaneous accept and take in BUSY keeps level at 1. Both counters increment at that same edge.
- `rst` asserted mid-operation: at the next edge all buffered beats are discarded, outputs return to their reset values, and counters clear. No partial beat is emitted afterwards.

## Structure
- Shared package `handshake_pkg`:
  - state localparams EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - default `DW`=8 and `CW`=16.
- Sub-module `beat_counter` (`CW`-bit wrapping counter with sync reset and an enable), instantiated twice: once for `in_cnt` on accept, once for `out_cnt` on take.
- Everything else stays in `skid_stage`.

## Test plan
- Streaming:
  - Stimulus: `up_valid`=1 with data 0x00..0x09 on consecutive cycles; `dn_ready`=1.
  - Required: 0x00..0x09 arrive in order, one per cycle, each 1 cycle after accept; `level` stays 1; final `in_cnt` = `out_cnt` = 10.
- Stall:
  - Stimulus: stream 0x10, 0x11, 0x12 with `dn_ready` dropped to 0 after 0x10 is presented.
  - Required: 0x11 lands in `skid_q`, `up_ready` falls, `level` = 2, `dn_data` holds 0x10; after `dn_ready` rises, 0x10, 0x11, 0x12 are delivered in order.
- Bubbles:
  - Stimulus: `up_valid` toggling 1,0,1,0 with data 0xA0, 0xA1; `dn_ready`=1.
  - Required: exactly two beats 0xA0 and 0xA1, with `dn_valid` low between them.
- Random backpressure:
  - Stimulus: 1000 random beats; `dn_ready` random at 50%.
  - Required: scoreboard shows zero loss, zero duplication, exact order; `in_cnt - out_cnt` == `level` every cycle.
- Reset mid-operation:
  - Stimulus: reach FULL holding 0x55/0x66, then pulse `rst` for 1 cycle.
  - Required: next cycle `dn_valid`=0, `up_ready`=0, counters 0; then `up_ready`=1; 0x55/0x66 never appear downstream.
- Counter wrap:
  - Stimulus: `CW`=4, stream 20 beats.
  - Required: `in_cnt` and `out_cnt` wrap 15 -> 0 and end at 4.
